// File: rtl/alu_pkg.sv
// Shared funct codes, muldiv opcodes and FSM states for the multicycle ALU.
// MULT/DIV codes are only decoded when SIGNED_MULDIV_EN is defined.
package alu_pkg;

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_DIV   = 6'd26;

  // muldiv core opcode: bit0 = divide, bit1 = signed
  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_SIGN,
    S_FINISH
  } state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Signed operation (sign-magnitude wrapper) only exists with SIGNED_MULDIV_EN.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic             r_busy;
  logic             r_done;
  logic             r_signed;
`ifdef SIGNED_MULDIV_EN
  logic             r_div;
  logic             r_neg_q;
  logic             r_neg_r;
`endif

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  // r_hi doubles as product high half / partial remainder; r_lo as multiplier / quotient
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
    w_diff    = w_rem_sh - {1'b0, r_b};
    w_a_mag   = a;
    w_b_mag   = b;
`ifdef SIGNED_MULDIV_EN
    if (op[1]) begin
      if (a[WIDTH-1]) w_a_mag = -a;
      if (b[WIDTH-1]) w_b_mag = -b;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_signed <= 1'b0;
`ifdef SIGNED_MULDIV_EN
      r_div    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_hi     <= '0;
            r_lo     <= w_a_mag;
            r_b      <= w_b_mag;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_signed <= op[1];
            r_state  <= op[0] ? S_DIV : S_MUL;
`ifdef SIGNED_MULDIV_EN
            r_div    <= op[0];
            r_neg_q  <= op[1] & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r  <= op[1] & a[WIDTH-1];
`endif
          end
        end
        S_MUL: begin
          {r_hi, r_lo} <= {w_mul_sum, r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= r_signed ? S_SIGN : S_FINISH;
            r_done  <= ~r_signed;
          end
        end
        S_DIV: begin
          if (!w_diff[WIDTH]) begin
            r_hi <= w_diff[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
          end else begin
            r_hi <= w_rem_sh[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= r_signed ? S_SIGN : S_FINISH;
            r_done  <= ~r_signed;
          end
        end
        S_SIGN: begin
`ifdef SIGNED_MULDIV_EN
          // remainder follows the dividend's sign, quotient the XOR of signs
          if (r_div) begin
            if (r_neg_q) r_lo <= -r_lo;
            if (r_neg_r) r_hi <= -r_hi;
          end else if (r_neg_q) begin
            {r_hi, r_lo} <= -{r_hi, r_lo};
          end
`endif
          r_state <= S_FINISH;
          r_done  <= 1'b1;
        end
        S_FINISH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: rtl/multicycle_alu_unit.sv
// EX-stage ALU: single-cycle ops, SRL, HI/LO pair and iterative MULTU/DIVU behind start/done.
// Define SIGNED_MULDIV_EN to add signed MULT/DIV; otherwise those codes are illegal.
module multicycle_alu_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Output,
  output logic             div_zero,
  output logic             illegal
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_out;
  logic             r_done;
  logic             r_dz;
  logic             r_ill;

  logic [WIDTH-1:0] w_res;
  logic             w_ill;
  logic             w_dz;
  logic             w_go;
  logic [1:0]       w_op;
  logic             w_wr;
  logic [WIDTH-1:0] w_hi_nx;
  logic [WIDTH-1:0] w_lo_nx;
  logic             w_accept;
  logic             w_seq_busy;
  logic             w_seq_done;
  logic [WIDTH-1:0] w_seq_hi;
  logic [WIDTH-1:0] w_seq_lo;

  assign w_accept = start & ~w_seq_busy;

  always_comb begin
    w_res   = '0;
    w_ill   = 1'b0;
    w_dz    = 1'b0;
    w_go    = 1'b0;
    w_op    = OP_MULU;
    w_wr    = 1'b0;
    w_hi_nx = r_hi;
    w_lo_nx = r_lo;
    case (Signal)
      F_AND:   w_res = dataA & dataB;
      F_OR:    w_res = dataA | dataB;
      F_ADD:   w_res = dataA + dataB;
      F_SUB:   w_res = dataA - dataB;
      F_SLT:   w_res = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
      F_SRL:   w_res = dataB >> dataA[SHAMT_W-1:0];
      F_MFHI:  w_res = r_hi;
      F_MFLO:  w_res = r_lo;
      F_MULTU: begin
        w_go = 1'b1;
        w_op = OP_MULU;
      end
      F_DIVU: begin
        // divide-by-zero bypasses the core and completes like a single-cycle op
        if (dataB == '0) begin
          w_dz    = 1'b1;
          w_wr    = 1'b1;
          w_hi_nx = dataA;
          w_lo_nx = '1;
          w_res   = '1;
        end else begin
          w_go = 1'b1;
          w_op = OP_DIVU;
        end
      end
`ifdef SIGNED_MULDIV_EN
      F_MULT: begin
        w_go = 1'b1;
        w_op = OP_MUL;
      end
      F_DIV: begin
        if (dataB == '0) begin
          w_dz    = 1'b1;
          w_wr    = 1'b1;
          w_hi_nx = dataA;
          w_lo_nx = '1;
          w_res   = '1;
        end else begin
          w_go = 1'b1;
          w_op = OP_DIV;
        end
      end
`endif
      default: w_ill = 1'b1;
    endcase
  end

  muldiv_seq #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk  (clk),
    .reset(reset),
    .start(w_accept & w_go),
    .op   (w_op),
    .a    (dataA),
    .b    (dataB),
    .busy (w_seq_busy),
    .done (w_seq_done),
    .hi   (w_seq_hi),
    .lo   (w_seq_lo)
  );

  // core results are presented directly in the done cycle, then committed on its closing edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_out  <= '0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      r_ill  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      r_ill  <= 1'b0;
      if (w_seq_done) begin
        r_out <= w_seq_lo;
        r_hi  <= w_seq_hi;
        r_lo  <= w_seq_lo;
      end else if (w_accept && !w_go) begin
        r_done <= 1'b1;
        r_out  <= w_res;
        r_ill  <= w_ill;
        r_dz   <= w_dz;
        if (w_wr) begin
          r_hi <= w_hi_nx;
          r_lo <= w_lo_nx;
        end
      end
    end
  end

  assign busy     = w_seq_busy;
  assign done     = r_done | w_seq_done;
  assign Output   = w_seq_done ? w_seq_lo : r_out;
  assign div_zero = r_dz;
  assign illegal  = r_ill;

endmodule

// File: tb/tb_multicycle_alu_unit.sv
// Directed self-checking bench for multicycle_alu_unit (WIDTH=32).
module tb_multicycle_alu_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        busy;
  logic        done;
  logic [31:0] Output;
  logic        div_zero;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  multicycle_alu_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .Signal(Signal),
    .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
    .Output(Output), .div_zero(div_zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // drive one start pulse; returns one cycle after the start cycle
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    Signal = f; dataA = a; dataB = b; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0;
    cyc(); cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (Output !== 32'h0) begin failures++; $display("FAIL rst_out got=%h exp=0", Output); end
    checks++; if (div_zero !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", div_zero, illegal); end
    reset = 1'b1;
    cyc();
  endtask

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic test_single_cycle();
    vec_t v[10];
    v[0] = '{F_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    v[1] = '{F_OR,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0};
    v[2] = '{F_ADD, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    v[3] = '{F_SUB, 32'h00000005, 32'h00000007, 32'hFFFFFFFE};
    v[4] = '{F_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    v[5] = '{F_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
    v[6] = '{F_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001};
    v[7] = '{F_SRL, 32'h00000004, 32'h80000000, 32'h08000000};
    v[8] = '{F_SRL, 32'h00000024, 32'h80000000, 32'h08000000};
    v[9] = '{F_SRL, 32'h0000001F, 32'h80000000, 32'h00000001};
    for (int i = 0; i < 10; i++) begin
      issue(v[i].f, v[i].a, v[i].b);
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL sc_hs[%0d] got done=%b busy=%b exp done=1 busy=0", i, done, busy); end
      checks++; if (Output !== v[i].exp) begin failures++; $display("FAIL sc_out[%0d] got=%h exp=%h", i, Output, v[i].exp); end
    end
    cyc();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL sc_done_pulse got=%b exp=0", done); end
    checks++; if (Output !== 32'h00000001) begin failures++; $display("FAIL sc_out_hold got=%h exp=00000001", Output); end
  endtask

  task automatic test_illegal();
    issue(6'd63, 32'h12345678, 32'h9ABCDEF0);
    checks++; if (done !== 1'b1 || illegal !== 1'b1) begin failures++; $display("FAIL ill_flag got done=%b illegal=%b exp 1 1", done, illegal); end
    checks++; if (Output !== 32'h0) begin failures++; $display("FAIL ill_out got=%h exp=0", Output); end
    cyc();
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL ill_pulse got=%b exp=0", illegal); end
`ifndef SIGNED_MULDIV_EN
    issue(F_MULT, 32'd3, 32'd5);
    checks++; if (illegal !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ill_mult got illegal=%b busy=%b exp 1 0", illegal, busy); end
    cyc();
`endif
  endtask

  task automatic test_multu();
    int k;
    issue(F_MULTU, 32'hFFFFFFFF, 32'd2);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL mul_busy got busy=%b done=%b exp 1 0", busy, done); end
    k = 1;
    while (!done && k < 100) begin cyc(); k++; end
    checks++; if (k != 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", k); end
    checks++; if (Output !== 32'hFFFFFFFE) begin failures++; $display("FAIL mul_out got=%h exp=FFFFFFFE", Output); end
    cyc();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mul_end got busy=%b done=%b exp 0 0", busy, done); end
    issue(F_MFHI, 32'h0, 32'h0);
    checks++; if (Output !== 32'h00000001) begin failures++; $display("FAIL mul_hi got=%h exp=00000001", Output); end
    issue(F_MFLO, 32'h0, 32'h0);
    checks++; if (Output !== 32'hFFFFFFFE) begin failures++; $display("FAIL mul_lo got=%h exp=FFFFFFFE", Output); end
  endtask

  task automatic test_divu();
    int k;
    issue(F_DIVU, 32'd100, 32'd7);
    k = 1;
    while (!done && k < 100) begin cyc(); k++; end
    checks++; if (k != 33) begin failures++; $display("FAIL div_latency got=%0d exp=33", k); end
    checks++; if (Output !== 32'd14) begin failures++; $display("FAIL div_out got=%h exp=0000000e", Output); end
    cyc();
    issue(F_MFHI, 32'h0, 32'h0);
    checks++; if (Output !== 32'd2) begin failures++; $display("FAIL div_hi got=%h exp=00000002", Output); end
    issue(F_MFLO, 32'h0, 32'h0);
    checks++; if (Output !== 32'd14) begin failures++; $display("FAIL div_lo got=%h exp=0000000e", Output); end
    issue(F_DIVU, 32'd5, 32'd0);
    checks++; if (done !== 1'b1 || div_zero !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL dz_flags got done=%b dz=%b busy=%b exp 1 1 0", done, div_zero, busy); end
    checks++; if (Output !== 32'hFFFFFFFF) begin failures++; $display("FAIL dz_out got=%h exp=FFFFFFFF", Output); end
    issue(F_MFHI, 32'h0, 32'h0);
    checks++; if (Output !== 32'd5 || div_zero !== 1'b0) begin failures++; $display("FAIL dz_hi got=%h dz=%b exp=00000005 dz=0", Output, div_zero); end
    issue(F_MFLO, 32'h0, 32'h0);
    checks++; if (Output !== 32'hFFFFFFFF) begin failures++; $display("FAIL dz_lo got=%h exp=FFFFFFFF", Output); end
  endtask

  task automatic test_start_while_busy();
    int k;
    int dones;
    int first;
    logic [31:0] res;
    issue(F_MULTU, 32'd3, 32'd5);
    for (int i = 0; i < 4; i++) cyc();
    Signal = F_DIVU; dataA = 32'd77; dataB = 32'd0; start = 1'b1;
    cyc();
    start = 1'b0; dataA = 32'hDEADBEEF; dataB = 32'h12345678;
    k = 6; dones = 0; first = 0; res = 32'h0;
    while (k < 60) begin
      if (done) begin
        dones++;
        if (first == 0) begin first = k; res = Output; end
      end
      cyc(); k++;
    end
    checks++; if (dones != 1) begin failures++; $display("FAIL busy_dones got=%0d exp=1", dones); end
    checks++; if (first != 33) begin failures++; $display("FAIL busy_latency got=%0d exp=33", first); end
    checks++; if (res !== 32'd15) begin failures++; $display("FAIL busy_prod got=%h exp=0000000f", res); end
    issue(F_MFHI, 32'h0, 32'h0);
    checks++; if (Output !== 32'h0) begin failures++; $display("FAIL busy_hi got=%h exp=0", Output); end
  endtask

  task automatic test_reset_mid_op();
    int dones;
    issue(F_DIVU, 32'd9, 32'd0);
    issue(F_DIVU, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) cyc();
    reset = 1'b0;
    cyc();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rmid_state got busy=%b done=%b exp 0 0", busy, done); end
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin cyc(); if (done) dones++; end
    checks++; if (dones != 0) begin failures++; $display("FAIL rmid_dones got=%0d exp=0", dones); end
    issue(F_MFHI, 32'h0, 32'h0);
    checks++; if (Output !== 32'h0) begin failures++; $display("FAIL rmid_hi got=%h exp=0", Output); end
    issue(F_MFLO, 32'h0, 32'h0);
    checks++; if (Output !== 32'h0) begin failures++; $display("FAIL rmid_lo got=%h exp=0", Output); end
  endtask

  task automatic test_back_to_back();
    issue(F_ADD, 32'd10, 32'd20);
    checks++; if (done !== 1'b1 || Output !== 32'd30) begin failures++; $display("FAIL b2b_first got done=%b out=%h exp 1 0000001e", done, Output); end
    issue(F_SUB, 32'd30, 32'd10);
    checks++; if (done !== 1'b1 || Output !== 32'd20) begin failures++; $display("FAIL b2b_second got done=%b out=%h exp 1 00000014", done, Output); end
    cyc();
  endtask

`ifdef SIGNED_MULDIV_EN
  task automatic test_signed();
    int k;
    issue(F_MULT, 32'hFFFFFFFD, 32'd5);
    k = 1;
    while (!done && k < 100) begin cyc(); k++; end
    checks++; if (k != 34) begin failures++; $display("FAIL smul_latency got=%0d exp=34", k); end
    cyc();
    issue(F_MFHI, 32'h0, 32'h0);
    checks++; if (Output !== 32'hFFFFFFFF) begin failures++; $display("FAIL smul_hi got=%h exp=FFFFFFFF", Output); end
    issue(F_MFLO, 32'h0, 32'h0);
    checks++; if (Output !== 32'hFFFFFFF1) begin failures++; $display("FAIL smul_lo got=%h exp=FFFFFFF1", Output); end
    issue(F_DIV, 32'hFFFFFFF9, 32'd2);
    k = 1;
    while (!done && k < 100) begin cyc(); k++; end
    checks++; if (Output !== 32'hFFFFFFFD) begin failures++; $display("FAIL sdiv_q got=%h exp=FFFFFFFD", Output); end
    cyc();
    issue(F_MFHI, 32'h0, 32'h0);
    checks++; if (Output !== 32'hFFFFFFFF) begin failures++; $display("FAIL sdiv_r got=%h exp=FFFFFFFF", Output); end
  endtask
`endif

  initial begin
    reset = 1'b0; start = 1'b0; Signal = 6'd0; dataA = 32'h0; dataB = 32'h0;
    #2;
    test_reset();
    test_single_cycle();
    test_illegal();
    test_multu();
    test_divu();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
`ifdef SIGNED_MULDIV_EN
    test_signed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
